// File: rtl/aether_pifo_pkg.sv
// Shared types and sizing helpers for the Aether PIFO controller.
// Entries carry a push sequence number below the rank so equal ranks pop FIFO.
package aether_pifo_pkg;
    localparam int ARITY = 4;
    localparam int SEQ_W = 32;
    localparam int PTW_DEF = 16;
    localparam int MTW_DEF = 32;

    typedef logic [MTW_DEF+PTW_DEF-1:0] entry_t;
    typedef enum logic {OP_PUSH = 1'b0, OP_POP = 1'b1} op_e;

    function automatic int nodes(input int level);
        return (4 ** level - 1) / 3;
    endfunction

    function automatic int cap(input int level);
        return ARITY * nodes(level);
    endfunction

    function automatic int cnt_w(input int level);
        return $clog2(cap(level) + 1);
    endfunction

    function automatic int lvl_of(input int idx);
        int l;
        l = 0;
        for (int k = 1; k <= 8; k++) begin
            if (idx >= nodes(k)) l = k;
        end
        return l;
    endfunction
endpackage

// File: rtl/aether_pifo_lvl_reg.sv
// Node input register; PASS turns it into a direct wire.
module aether_pifo_lvl_reg
    import aether_pifo_pkg::*;
#(
    parameter int EW   = 80,
    parameter bit PASS = 1'b0
) (
    input  logic          i_clk,
    input  logic          i_arst_n,
    input  logic          i_valid,
    input  logic          i_op,
    input  logic [EW-1:0] i_ent,
    output logic          o_valid,
    output logic          o_op,
    output logic [EW-1:0] o_ent
);
    logic          valid_q, valid_d;
    logic          op_q, op_d;
    logic [EW-1:0] ent_q, ent_d;

    always_comb begin
        valid_d = i_valid;
        op_d    = i_op;
        ent_d   = i_ent;
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            valid_q <= 1'b0;
            op_q    <= OP_PUSH;
            ent_q   <= '0;
        end else begin
            valid_q <= valid_d;
            op_q    <= op_d;
            ent_q   <= ent_d;
        end
    end

    assign o_valid = PASS ? i_valid : valid_q;
    assign o_op    = PASS ? i_op : op_q;
    assign o_ent   = PASS ? i_ent : ent_q;
endmodule

// File: rtl/aether_pifo_node.sv
// One 4-slot PIFO heap node; each slot heads a child subtree with its count.
// Pops refill the slot from the child's post-pending-op minimum.
module aether_pifo_node
    import aether_pifo_pkg::*;
#(
    parameter int EW = 80,
    parameter int KW = 48,
    parameter int CW = 5
) (
    input  logic             i_clk,
    input  logic             i_arst_n,
    input  logic             i_valid,
    input  logic             i_op,
    input  logic [EW-1:0]    i_ent,
    input  logic [EW-1:0]    i_ch_min [ARITY],
    output logic             o_c_valid,
    output logic [ARITY-1:0] o_c_mask,
    output logic             o_c_op,
    output logic [EW-1:0]    o_c_ent,
    output logic [EW-1:0]    o_min_cur,
    output logic [EW-1:0]    o_min_nxt
);
    logic          vld_q [ARITY];
    logic          vld_d [ARITY];
    logic [EW-1:0] ent_q [ARITY];
    logic [EW-1:0] ent_d [ARITY];
    logic [CW-1:0] cnt_q [ARITY];
    logic [CW-1:0] cnt_d [ARITY];
    logic [1:0]    mi, ei, li, ni;
    logic          fnd, has_e, fnd_n;

    // Searches over settled state only, so parents can read o_min_cur freely.
    always_comb begin
        mi    = '0;
        ei    = '0;
        li    = '0;
        fnd   = 1'b0;
        has_e = 1'b0;
        for (int s = 0; s < ARITY; s++) begin
            if (vld_q[s] && (!fnd ||
                ent_q[s][KW-1:0] < ent_q[mi][KW-1:0])) begin
                mi  = 2'(s);
                fnd = 1'b1;
            end
            if (!vld_q[s] && !has_e) begin
                ei    = 2'(s);
                has_e = 1'b1;
            end
            if (cnt_q[s] < cnt_q[li]) li = 2'(s);
        end
    end

    always_comb begin
        vld_d     = vld_q;
        ent_d     = ent_q;
        cnt_d     = cnt_q;
        o_c_valid = 1'b0;
        o_c_mask  = '0;
        o_c_op    = i_op;
        o_c_ent   = i_ent;
        if (i_valid && i_op == OP_POP) begin
            if (cnt_q[mi] != '0) begin
                ent_d[mi]    = i_ch_min[mi];
                cnt_d[mi]    = cnt_q[mi] - CW'(1);
                o_c_valid    = 1'b1;
                o_c_mask[mi] = 1'b1;
            end else begin
                vld_d[mi] = 1'b0;
            end
        end else if (i_valid && has_e) begin
            vld_d[ei] = 1'b1;
            ent_d[ei] = i_ent;
        end else if (i_valid) begin
            cnt_d[li]    = cnt_q[li] + CW'(1);
            o_c_valid    = 1'b1;
            o_c_mask[li] = 1'b1;
            if (i_ent[KW-1:0] < ent_q[li][KW-1:0]) begin
                ent_d[li] = i_ent;
                o_c_ent   = ent_q[li];
            end
        end
    end

    always_comb begin
        ni    = '0;
        fnd_n = 1'b0;
        for (int s = 0; s < ARITY; s++) begin
            if (vld_d[s] && (!fnd_n ||
                ent_d[s][KW-1:0] < ent_d[ni][KW-1:0])) begin
                ni    = 2'(s);
                fnd_n = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            for (int s = 0; s < ARITY; s++) begin
                vld_q[s] <= 1'b0;
                ent_q[s] <= '0;
                cnt_q[s] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            ent_q <= ent_d;
            cnt_q <= cnt_d;
        end
    end

    assign o_min_cur = ent_q[mi];
    assign o_min_nxt = ent_d[ni];
endmodule

// File: rtl/aether_pifo_ctrl_top.sv
// Flow-controlled PIFO tree: handshakes, occupancy, flags, sticky error
// and pop-valid alignment around a 4-ary tree of heap nodes.
module aether_pifo_ctrl_top
    import aether_pifo_pkg::*;
#(
    parameter int PTW        = 16,
    parameter int MTW        = 32,
    parameter int LEVEL      = 4,
    parameter int REG_STRIDE = 1,
    parameter int POP_LAT    = 1,
    parameter int AFULL_TH   = cap(LEVEL) - 4
) (
    input  logic                     i_clk,
    input  logic                     i_arst_n,
    input  logic                     i_push_valid,
    output logic                     o_push_ready,
    input  logic                     i_pop_valid,
    output logic                     o_pop_ready,
    input  logic [MTW+PTW-1:0]       i_data,
    output logic [MTW+PTW-1:0]       o_pop_data,
    output logic                     o_pop_valid,
    output logic [cnt_w(LEVEL)-1:0]  o_count,
    output logic                     o_empty,
    output logic                     o_full,
    output logic                     o_afull,
    output logic                     o_err,
    input  logic                     i_err_clr
);
    localparam int NODES = nodes(LEVEL);
    localparam int CAP   = cap(LEVEL);
    localparam int CW    = cnt_w(LEVEL);
    localparam int DW    = MTW + PTW;
    localparam int EW    = DW + SEQ_W;
    localparam int KW    = PTW + SEQ_W;

    logic               pop_acc, push_acc;
    op_e                acc_op;
    logic [CW-1:0]      count_q, count_d;
    logic               err_q, err_d;
    logic [SEQ_W-1:0]   seq_q, seq_d;
    logic [POP_LAT-1:0] psh_q, psh_d;
    logic [DW-1:0]      dl_q [POP_LAT];
    logic [DW-1:0]      dl_d [POP_LAT];
    logic [DW-1:0]      hold_q, hold_d;
    logic [DW-1:0]      root_pop, aligned;

    assign o_empty      = count_q == '0;
    assign o_full       = count_q == CW'(CAP);
    assign o_afull      = count_q >= CW'(AFULL_TH);
    assign o_pop_ready  = !o_empty;
    assign o_push_ready = !o_full && !(i_pop_valid && !o_empty);
    assign pop_acc      = i_pop_valid && o_pop_ready;
    assign push_acc     = i_push_valid && o_push_ready;
    assign acc_op       = pop_acc ? OP_POP : OP_PUSH;

    always_comb begin
        count_d = count_q;
        if (pop_acc) count_d = count_q - CW'(1);
        else if (push_acc) count_d = count_q + CW'(1);
        seq_d = push_acc ? seq_q + SEQ_W'(1) : seq_q;
        err_d = err_q;
        if (i_err_clr) err_d = 1'b0;
        if ((i_pop_valid && o_empty) || (i_push_valid && o_full))
            err_d = 1'b1;
        psh_d[0] = pop_acc;
        dl_d[0]  = root_pop;
        for (int k = 1; k < POP_LAT; k++) begin
            psh_d[k] = psh_q[k-1];
            dl_d[k]  = dl_q[k-1];
        end
        hold_d = o_pop_valid ? aligned : hold_q;
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            count_q <= '0;
            err_q   <= 1'b0;
            seq_q   <= '0;
            psh_q   <= '0;
            hold_q  <= '0;
            for (int k = 0; k < POP_LAT; k++) dl_q[k] <= '0;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
            seq_q   <= seq_d;
            psh_q   <= psh_d;
            hold_q  <= hold_d;
            dl_q    <= dl_d;
        end
    end

    if (POP_LAT == 1) begin : g_lat1
        assign aligned = root_pop;
    end else begin : g_latn
        assign aligned = dl_q[POP_LAT-2];
    end

    assign o_pop_valid = psh_q[POP_LAT-1];
    assign o_pop_data  = o_pop_valid ? aligned : hold_q;
    assign o_count     = count_q;
    assign o_err       = err_q;

    for (genvar i = 0; i < NODES; i++) begin : g_node
        localparam bit PASS =
            (i != 0) && (lvl_of(i) % REG_STRIDE != 0);
        logic             up_v, up_op, in_v, in_op, c_v, c_op;
        logic [EW-1:0]    up_e, in_e, c_e, min_cur, min_nxt, min_sel;
        logic [ARITY-1:0] c_m;
        logic [EW-1:0]    ch_min [ARITY];

        if (i == 0) begin : g_root
            assign up_v  = pop_acc || push_acc;
            assign up_op = acc_op;
            assign up_e  = {i_data, seq_q};
        end else begin : g_child
            assign up_v  = g_node[(i-1)/4].c_v &
                           g_node[(i-1)/4].c_m[(i-1)%4];
            assign up_op = g_node[(i-1)/4].c_op;
            assign up_e  = g_node[(i-1)/4].c_e;
        end

        if (4 * i + 1 < NODES) begin : g_kids
            for (genvar c = 0; c < ARITY; c++) begin : g_c
                assign ch_min[c] = g_node[4*i+1+c].min_sel;
            end
        end else begin : g_leaf
            for (genvar c = 0; c < ARITY; c++) begin : g_c
                assign ch_min[c] = '0;
            end
        end

        aether_pifo_lvl_reg #(.EW(EW), .PASS(PASS)) u_reg (
            .i_clk   (i_clk),
            .i_arst_n(i_arst_n),
            .i_valid (up_v),
            .i_op    (up_op),
            .i_ent   (up_e),
            .o_valid (in_v),
            .o_op    (in_op),
            .o_ent   (in_e)
        );

        aether_pifo_node #(.EW(EW), .KW(KW), .CW(CW)) u_node (
            .i_clk    (i_clk),
            .i_arst_n (i_arst_n),
            .i_valid  (in_v),
            .i_op     (in_op),
            .i_ent    (in_e),
            .i_ch_min (ch_min),
            .o_c_valid(c_v),
            .o_c_mask (c_m),
            .o_c_op   (c_op),
            .o_c_ent  (c_e),
            .o_min_cur(min_cur),
            .o_min_nxt(min_nxt)
        );

        // A wired boundary means the child applies our op this same cycle.
        assign min_sel = PASS ? min_cur : min_nxt;
    end

    assign root_pop = g_node[0].min_cur[EW-1:SEQ_W];
endmodule

// File: tb/tb_aether_pifo_ctrl_top.sv
// Directed bench for aether_pifo_ctrl_top with a two-level tree (CAP=20).
module tb_aether_pifo_ctrl_top;
    localparam int DW = 48;

    logic          i_clk = 1'b0;
    logic          i_arst_n = 1'b0;
    logic          push_v = 1'b0;
    logic          pop_v = 1'b0;
    logic          err_clr = 1'b0;
    logic [DW-1:0] data = '0;
    logic          push_rdy, pop_rdy, pop_vld;
    logic          empty, full, afull, err;
    logic [DW-1:0] pop_data;
    logic [4:0]    count;
    int            errors = 0;
    int            checks = 0;
    int            rk [5] = '{9, 3, 7, 3, 3};
    int            mt [5] = '{1, 2, 3, 'hA, 'hB};
    logic [DW-1:0] exp_ord [5];

    aether_pifo_ctrl_top #(.LEVEL(2), .REG_STRIDE(1), .POP_LAT(1)) dut (
        .i_clk       (i_clk),
        .i_arst_n    (i_arst_n),
        .i_push_valid(push_v),
        .o_push_ready(push_rdy),
        .i_pop_valid (pop_v),
        .o_pop_ready (pop_rdy),
        .i_data      (data),
        .o_pop_data  (pop_data),
        .o_pop_valid (pop_vld),
        .o_count     (count),
        .o_empty     (empty),
        .o_full      (full),
        .o_afull     (afull),
        .o_err       (err),
        .i_err_clr   (err_clr)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [DW-1:0] ent(input int rank, input int meta);
        return {meta[31:0], rank[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        exp_ord[0] = ent(3, 2);
        exp_ord[1] = ent(3, 'hA);
        exp_ord[2] = ent(3, 'hB);
        exp_ord[3] = ent(7, 3);
        exp_ord[4] = ent(9, 1);

        repeat (2) @(negedge i_clk);
        chk("rst_push_ready", push_rdy, 1);
        chk("rst_pop_ready", pop_rdy, 0);
        chk("rst_pop_valid", pop_vld, 0);
        chk("rst_pop_data", pop_data, 0);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_afull", afull, 0);
        chk("rst_err", err, 0);
        i_arst_n = 1'b1;
        repeat (5) begin
            @(negedge i_clk);
            chk("idle_pop_valid", pop_vld, 0);
        end
        chk("idle_empty", empty, 1);
        chk("idle_count", count, 0);
        chk("idle_pop_ready", pop_rdy, 0);

        // Rank ordering with FIFO tie-break, back-to-back pops.
        push_v = 1'b1;
        for (int i = 0; i < 5; i++) begin
            data = ent(rk[i], mt[i]);
            @(negedge i_clk);
        end
        push_v = 1'b0;
        chk("ord_count", count, 5);
        pop_v = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge i_clk);
            if (k == 4) pop_v = 1'b0;
            chk("ord_pop_valid", pop_vld, 1);
            chk("ord_pop_data", pop_data, exp_ord[k]);
        end
        @(negedge i_clk);
        chk("ord_pop_valid_off", pop_vld, 0);
        chk("ord_hold", pop_data, ent(9, 1));
        chk("ord_count_end", count, 0);
        chk("ord_err", err, 0);

        // Pop while empty.
        pop_v = 1'b1;
        @(negedge i_clk);
        pop_v = 1'b0;
        chk("empty_pop_err", err, 1);
        chk("empty_pop_count", count, 0);
        chk("empty_pop_valid", pop_vld, 0);
        @(negedge i_clk);
        chk("empty_pop_valid2", pop_vld, 0);
        err_clr = 1'b1;
        @(negedge i_clk);
        err_clr = 1'b0;
        chk("err_cleared", err, 0);

        // Fill to capacity.
        push_v = 1'b1;
        for (int k = 0; k < 20; k++) begin
            data = ent(20 - k, k);
            @(negedge i_clk);
            if (k == 14) chk("afull_15", afull, 0);
            if (k == 15) chk("afull_16", afull, 1);
        end
        data = ent(99, 99);
        chk("full_flag", full, 1);
        chk("full_count", count, 20);
        chk("full_push_ready", push_rdy, 0);
        @(negedge i_clk);
        chk("full_push_err", err, 1);
        chk("full_count_hold", count, 20);
        err_clr = 1'b1;
        @(negedge i_clk);
        chk("err_set_wins", err, 1);
        push_v = 1'b0;
        @(negedge i_clk);
        err_clr = 1'b0;
        chk("err_clr_full", err, 0);

        // Drain 15 in ascending rank.
        pop_v = 1'b1;
        for (int j = 0; j < 15; j++) begin
            @(negedge i_clk);
            if (j == 14) pop_v = 1'b0;
            chk("drain_data", pop_data, ent(j + 1, 19 - j));
        end
        chk("drain_count", count, 5);

        // Push and pop together: pop wins.
        push_v = 1'b1;
        pop_v = 1'b1;
        data = ent(1, 'h77);
        #1;
        chk("both_push_ready", push_rdy, 0);
        chk("both_pop_ready", pop_rdy, 1);
        @(negedge i_clk);
        push_v = 1'b0;
        pop_v = 1'b0;
        chk("both_count", count, 4);
        chk("both_pop_valid", pop_vld, 1);
        chk("both_pop_data", pop_data, ent(16, 4));
        @(negedge i_clk);
        chk("both_count_hold", count, 4);

        // Reset with pops in flight.
        pop_v = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        i_arst_n = 1'b0;
        pop_v = 1'b0;
        @(negedge i_clk);
        chk("mid_rst_pop_valid", pop_vld, 0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_empty", empty, 1);
        @(negedge i_clk);
        i_arst_n = 1'b1;
        repeat (4) begin
            @(negedge i_clk);
            chk("post_rst_pop_valid", pop_vld, 0);
        end
        chk("post_rst_count", count, 0);
        chk("post_rst_empty", empty, 1);
        chk("post_rst_push_ready", push_rdy, 1);

        // Pop accepted the cycle after push acceptance.
        push_v = 1'b1;
        data = ent(5, 'hCAFE);
        @(negedge i_clk);
        push_v = 1'b0;
        pop_v = 1'b1;
        @(negedge i_clk);
        pop_v = 1'b0;
        chk("pap_pop_valid", pop_vld, 1);
        chk("pap_pop_data", pop_data, ent(5, 'hCAFE));
        chk("pap_count", count, 0);
        @(negedge i_clk);
        chk("pap_pop_valid_off", pop_vld, 0);
        chk("pap_hold", pop_data, ent(5, 'hCAFE));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/aether_pifo_ctrl_top.md
# aether_pifo_ctrl_top

Flow-controlled, parametrised successor to the Aether PIFO tree top. Instantiates a 4-ary systolic tree of Aether_PIFO_Node of configurable depth and inter-level register stride. Adds valid/ready push and pop handshakes, occupancy tracking, full/almost-full/empty flags, an aligned pop-valid strobe and sticky error reporting. Sits between the flow scheduler front end and the egress arbiter.

## Interface
- PTW, 16, rank (priority) field width; occupies i_data[PTW-1:0].
- MTW, 32, metadata width; occupies i_data[MTW+PTW-1:PTW].
- LEVEL, 4, tree depth (1..8); NODES = (4^LEVEL-1)/3; CAP = 4*NODES entries.
- REG_STRIDE, 1, inter-level register every REG_STRIDE levels (1..LEVEL); unregistered boundaries are direct wires.
- POP_LAT, 1, cycles from accepted pop to o_pop_valid (node pop-data latency + 1 root input register); must be ≥1.
- AFULL_TH, CAP-4, o_afull threshold.

Ports:
- i_clk  in  1  clock.
- i_arst_n  in  1  reset, asynchronous, active-low.
- i_push_valid  in  1  push request.
- o_push_ready  out  1  push accepted when both high.
- i_pop_valid  in  1  pop request.
- o_pop_ready  out  1  pop accepted when both high.
- i_data  in  MTW+PTW  push entry.
- o_pop_data  out  MTW+PTW  popped entry; qualified by o_pop_valid.
- o_pop_valid  out  1  one-cycle strobe per accepted pop.
- o_count  out  $clog2(CAP+1)  occupancy.
- o_empty, o_full, o_afull  out  1 each  flags from o_count.
- o_err  out  1  sticky: pop_valid while empty, or push_valid while full.
- i_err_clr  in  1  synchronous clear of o_err.

## Operation
- Exactly one op enters the root per cycle. Pop has priority over push.
- o_pop_ready = !o_empty. o_push_ready = !o_full && !(i_pop_valid && !o_empty) (combinational from i_pop_valid).
- Accepted op drives root input register: valid=1, op=1 for pop / 0 for push, data=i_data (don't-care on pop).
- Child input register i (i>0): parent P=(i-1)/4, position C=(i-1)%4; valid = parent o_c_valid & o_c_mask[C]; op/data copied. Registered only where level boundary index is a multiple of REG_STRIDE; otherwise combinational pass-through.
- o_count: +1 on accepted push, -1 on accepted pop, never both. Saturation never reached because ready gating prevents overflow and underflow.
- o_empty = (count==0); o_full = (count==CAP); o_afull = (count≥AFULL_TH).
- o_err set when (i_pop_valid && o_empty) or (i_push_valid && o_full). i_err_clr clears it; a set condition in the same cycle wins.
- Pop pipeline: POP_LAT-deep shift register of accepted-pop bits produces o_pop_valid. o_pop_data = root node o_pop_data, registered on the o_pop_valid cycle and held until the next pop.
- Pop after push: the entry is visible to a pop accepted the cycle after push acceptance. Descending-level writes never block root ordering; the node contract guarantees this.

## Timing
- Reset values: o_push_ready=1, o_pop_ready=0, o_pop_valid=0, o_pop_data=0, o_count=0, o_empty=1, o_full=0, o_afull=(AFULL_TH==0), o_err=0. All valid registers and the pop shift register are cleared.
- Reset mid-operation discards all in-flight ops and contents. No pop_valid is produced for pops accepted before reset.
- Flags and count update the cycle after acceptance.
- Throughput is 1 op/cycle sustained. Back-to-back pops return entries in non-decreasing rank. Equal ranks return FIFO order.

## Structure
- Package aether_pifo_pkg: function nodes(level), localparam-style functions cap(level) and cnt_w(level), and typedef entry_t = logic [MTW+PTW-1:0] (parametrised via macro or per-instance typedef).
- Sub-module aether_pifo_lvl_reg: parametrised-bypass register (valid/op/data) with PASS parameter, instantiated per node input.
- Top holds the handshake, counter, flags, error and pop-alignment logic.

## Test plan
- Reset, then idle 5 cycles -> o_empty=1, o_pop_ready=0, o_count=0, o_pop_valid never asserts.
- LEVEL=2 (CAP=20): push ranks 9,3,7,3(meta 0xA),3(meta 0xB), then pop ×5 -> ranks 3(A? FIFO order 3 first),3A,3B,7,9; o_pop_valid exactly POP_LAT after each accept.
- LEVEL=2: push 20 entries -> o_full=1, o_push_ready=0; 21st push_valid sets o_err; i_err_clr clears it next cycle.
- Push and pop valid together with count=5 -> only pop accepted, count=4, push_ready low that cycle.
- Pop_valid while empty -> no acceptance, o_err=1, count stays 0.
- Assert i_arst_n low with 3 pops in flight -> zero o_pop_valid after release, count=0, o_empty=1.
